// File: rtl/wb_scoreboard.sv
// wb_scoreboard: owns the register-file write port and tracks registers with results outstanding.
module wb_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [ADDR_WIDTH-1:0]    iss_rd,
  input  logic [ADDR_WIDTH-1:0]    iss_rs1,
  input  logic [ADDR_WIDTH-1:0]    iss_rs2,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic                     err
);
  localparam int NREG = 2**ADDR_WIDTH;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  rr_q, rr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  haz, iss_fire, exu_g, lsu_g, any_g;
  logic [ADDR_WIDTH-1:0] g_rd;
  logic [DATA_WIDTH-1:0] g_data;
  // rr_q=1 means LSU wins the next contended cycle; readies derive only from valids and state
  always_comb begin
    haz = (iss_rs1 != '0 && busy_q[iss_rs1]) || (iss_rs2 != '0 && busy_q[iss_rs2]) ||
          (iss_rd != '0 && busy_q[iss_rd]);
    iss_ready = reset && !haz;
    iss_fire = iss_valid && iss_ready;
    exu_g = reset && exu_valid && (!lsu_valid || !rr_q);
    lsu_g = reset && lsu_valid && (!exu_valid || rr_q);
    any_g = exu_g || lsu_g;
    g_rd = lsu_g ? lsu_rd : exu_rd;
    g_data = lsu_g ? lsu_data : exu_data;
    rr_d = (exu_valid && lsu_valid) ? !rr_q : rr_q;
    wen_d = any_g && g_rd != '0;
    waddr_d = any_g ? g_rd : waddr_q;
    wdata_d = any_g ? g_data : wdata_q;
    err_d = err_q || (wen_d && !busy_q[g_rd]);
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q  <= '0;
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  assign exu_ready = exu_g;
  assign lsu_ready = lsu_g;
  assign rf_wen    = wen_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed plus random stimulus against a pending-set model; writes checked by a scoreboard monitor.
module tb_wb_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clock, reset;
  logic iss_valid, iss_ready, exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2, exu_rd, lsu_rd, rf_waddr;
  logic [DW-1:0] exu_data, lsu_data, rf_wdata;
  logic rf_wen, err;
  logic [2**AW-1:0] busy;
  wb_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .err(err)
  );
  typedef struct {int cyc; logic [AW-1:0] rd; logic [DW-1:0] d;} wr_t;
  wr_t sbq[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [2**AW-1:0] mbusy = '0;
  logic merr = 1'b0, lsu_turn = 1'b0, wr_pend = 1'b0;
  logic [AW-1:0] wr_rd = '0;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask
  // Monitor: every register-file write must match the oldest accepted result, one cycle later.
  always @(negedge clock) begin
    wr_t e;
    if (rf_wen === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL rf_write_unexpected: got addr %0d data %0h expected no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
      end else begin
        e = sbq.pop_front();
        chk("rf_write_cycle", 64'(cyc), 64'(e.cyc));
        chk("rf_waddr", 64'(rf_waddr), 64'(e.rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_chk++;
      $display("FAIL rf_write_missing: got rf_wen %b expected write x%0d=%0h (cycle %0d)", rf_wen, e.rd, e.d, cyc);
    end
  end
  // Reference model: a set of pending registers, a sticky error and whose turn it is on contention.
  always @(negedge clock) begin
    logic e_iss, e_exu, e_lsu;
    logic [AW-1:0] grd;
    logic [DW-1:0] gd;
    #1;
    e_iss = reset && !((iss_rs1 != 0 && mbusy[iss_rs1]) || (iss_rs2 != 0 && mbusy[iss_rs2]) ||
                       (iss_rd != 0 && mbusy[iss_rd]));
    e_exu = reset && exu_valid && (!lsu_valid || !lsu_turn);
    e_lsu = reset && lsu_valid && !e_exu;
    chk("iss_ready", 64'(iss_ready), 64'(e_iss));
    chk("exu_ready", 64'(exu_ready), 64'(e_exu));
    chk("lsu_ready", 64'(lsu_ready), 64'(e_lsu));
    chk("busy", 64'(busy), 64'(mbusy));
    chk("err", 64'(err), 64'(merr));
    if (!reset) begin
      mbusy = '0;
      merr = 1'b0;
      lsu_turn = 1'b0;
      wr_pend = 1'b0;
      sbq.delete();
    end else begin
      grd = e_lsu ? lsu_rd : exu_rd;
      gd = e_lsu ? lsu_data : exu_data;
      if ((e_exu || e_lsu) && grd != 0 && !mbusy[grd]) merr = 1'b1;
      if (wr_pend) mbusy[wr_rd] = 1'b0;
      wr_pend = (e_exu || e_lsu) && grd != 0;
      wr_rd = grd;
      if (wr_pend) sbq.push_back('{cyc + 1, grd, gd});
      if (exu_valid && lsu_valid) lsu_turn = !lsu_turn;
      if (iss_valid && e_iss && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    iss_valid = 0; exu_valid = 0; lsu_valid = 0;
  endtask
  task automatic iss(logic [AW-1:0] rd, logic [AW-1:0] rs1, logic [AW-1:0] rs2);
    iss_valid = 1; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
  endtask
  task automatic exu(logic [AW-1:0] rd, logic [DW-1:0] d);
    exu_valid = 1; exu_rd = rd; exu_data = d;
  endtask
  task automatic lsu(logic [AW-1:0] rd, logic [DW-1:0] d);
    lsu_valid = 1; lsu_rd = rd; lsu_data = d;
  endtask
  function automatic logic [AW-1:0] pick_rd();
    logic [AW-1:0] r;
    if ($urandom_range(9) == 0) return AW'($urandom_range(31));
    for (int k = 0; k < 12; k++) begin
      r = AW'($urandom_range(1, 31));
      if (mbusy[r]) return r;
    end
    return AW'($urandom_range(15));
  endfunction
  initial begin
    reset = 0;
    iss(5, 1, 2); exu(1, 32'h1); lsu(2, 32'h2);
    tick(); tick();
    reset = 1; idle(); iss(5, 1, 2);
    tick();
    iss(6, 5, 0);
    tick();
    exu(5, 32'hDEADBEEF);
    tick();
    exu_valid = 0;
    tick(); tick();
    idle(); iss(3, 0, 0);
    tick();
    iss(4, 0, 0);
    tick();
    idle(); exu(3, 32'h11); lsu(4, 32'h22);
    tick(); tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      iss(AW'(10 + i), 0, 0);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      exu(AW'(10 + 2 * ((i + 1) / 2)), 32'hE000 + i);
      lsu(AW'(11 + 2 * (i / 2)), 32'hA000 + i);
      tick();
    end
    idle(); iss(0, 0, 0); lsu(0, 32'h55);
    tick();
    idle(); exu(7, 32'h77);
    tick();
    idle();
    tick(); tick();
    iss(9, 0, 0);
    tick();
    idle(); reset = 0;
    tick();
    reset = 1; exu(9, 32'h99);
    tick();
    idle(); iss(20, 9, 0);
    tick();
    idle();
    tick();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(79) != 0);
      iss_valid = $urandom_range(3) != 0;
      iss_rd = AW'($urandom_range(15));
      iss_rs1 = AW'($urandom_range(15));
      iss_rs2 = AW'($urandom_range(15));
      exu_valid = $urandom_range(2) != 0;
      exu_rd = pick_rd();
      exu_data = $urandom;
      lsu_valid = $urandom_range(2) != 0;
      lsu_rd = pick_rd();
      lsu_data = $urandom;
      tick();
    end
    reset = 1; idle();
    tick(); tick(); tick();
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Write-side companion to the register file: owns its single write port (wen/waddr/wdata) and tracks which architectural registers have results outstanding.
- Issue stage reserves rd through a valid/ready handshake and is stalled on RAW/WAW hazards.
- EXU and LSU return results through independent valid/ready handshakes.
- Results are arbitrated round-robin and registered, giving at most one register-file write per cycle.

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 hard-wired zero.
- DATA_WIDTH, 32, register data width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clock).
- iss_valid  in  1  issue stage presents an instruction.
- iss_ready  out  1  instruction may issue this cycle.
- iss_rd  in  ADDR_WIDTH  destination register of the issuing instruction.
- iss_rs1  in  ADDR_WIDTH  first source register.
- iss_rs2  in  ADDR_WIDTH  second source register.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  EXU result accepted.
- exu_rd  in  ADDR_WIDTH  EXU result destination.
- exu_data  in  DATA_WIDTH  EXU result value.
- lsu_valid  in  1  LSU result valid.
- lsu_ready  out  1  LSU result accepted.
- lsu_rd  in  ADDR_WIDTH  LSU result destination.
- lsu_data  in  DATA_WIDTH  LSU result value.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- busy  out  2**ADDR_WIDTH  per-register pending bits; bit 0 is always 0.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset==0 at rising edge):
  - busy=0, rf_wen=0, rf_waddr=0, rf_wdata=0, err=0.
  - Round-robin pointer set to EXU-first.
  - Applies identically mid-operation: pending reservations and any staged write are discarded.
  - While reset is low, iss_ready, exu_ready and lsu_ready are 0.
- Hazard check (combinational):
  - haz = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]) || (rd!=0 && busy[rd]).
  - iss_ready = !haz.
  - Issue fires when iss_valid && iss_ready.
- Reservation: on issue fire with iss_rd!=0, busy[iss_rd] is set at the next edge. iss_rd==0 reserves nothing.
- Arbitration (combinational):
  - Exactly one source valid: that source is granted.
  - Both valid: the pointer's source is granted; the pointer flips to the other source at the edge.
  - Uncontended grants do not move the pointer.
  - exu_ready / lsu_ready equal the grant, and never depend on the ready outputs of other stages.
  - At most one ready is high per cycle.
- Write stage (registered, 1-cycle latency):
  - On a granted result in cycle N: in cycle N+1, rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=data.
  - With no grant in cycle N: rf_wen=0 in N+1, and rf_waddr/rf_wdata hold their previous values.
- Release:
  - In the cycle rf_wen=1, busy[rf_waddr] clears at the closing edge, the same edge on which the register file commits.
  - Issue in the next cycle therefore sees busy=0 and reads the new value.
- Same-cycle clear/set on one register: this cannot legally occur, because issue of rd requires busy[rd]=0. If it does occur, set wins.
- Result to rd==0: accepted, no write, no busy change.
- Result to a register whose busy bit is 0 (rd!=0):
  - Still written.
  - err is set and stays set until reset.
- Throughput: one result accepted per cycle sustained. A single source is never stalled.
- Each source is starved for at most 1 cycle under continuous contention.

Test Plan:
- Reset low 2 cycles with all valids high -> all readies 0, busy=0, rf_wen=0. Release reset -> iss_ready=1 for rd=5, rs=1,2.
- Issue rd=5; next cycle issue rs1=5 -> second issue blocked (iss_ready=0). EXU returns rd=5, data=0xDEADBEEF -> rf_wen=1, waddr=5, wdata=0xDEADBEEF exactly one cycle after acceptance. busy[5] clears; dependent issue proceeds the following cycle.
- Reserve x3 and x4. EXU (rd=3, 0x11) and LSU (rd=4, 0x22) both valid for 2 cycles -> EXU granted first, LSU second. Writes x3 then x4 on consecutive cycles; busy[3], busy[4] clear in that order.
- Both sources continuously valid for 6 cycles -> grants alternate E,L,E,L,E,L; rf_wen high every cycle.
- Issue rd=0; LSU returns rd=0, data=0x55 -> iss_ready stays 1, lsu_ready=1, rf_wen=0, busy unchanged, err=0. EXU returns rd=7 with busy[7]=0 -> x7 written, err=1 and held.
- Reserve x9, then pulse reset low 1 cycle before the EXU result arrives -> busy[9]=0, rf_wen=0, err=0. The later issue with rs1=9 is not stalled.
